// File: rtl/prime_seg_display.sv
// prime_seg_display
//   Converts a 20-bit unsigned binary value (a prime from the upstream sieve)
//   into 7 BCD digits using a sequential double-dabble engine. The result is
//   shown on an 8-digit multiplexed seven-segment display.
//
// Parameters
//   SCAN_DIV   clk cycles each digit is displayed (>= 2)
//
// Ports
//   clk        sole clock, rising edge
//   rst        asynchronous, active-high reset
//   din_valid  single-cycle strobe qualifying din (ignored while busy)
//   din[19:0]  unsigned binary value to convert
//   busy       high from the accept edge until the FSM returns to IDLE
//   bcd_valid  one-cycle pulse when bcd_out updates
//   bcd_out    7 BCD digits, [3:0] = ones
//   an[7:0]    active-low one-hot digit enable, bit 0 = rightmost digit
//   seg[7:0]   active-low segments, bit 7 = dp (always off), bits 6:0 = g..a
//
// Build option
//   LEADING_ZERO_BLANK_EN  when defined, digits above the most-significant
//                          nonzero digit are blanked (value 0 shows one '0').
module prime_seg_display #(
  parameter int SCAN_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        din_valid,
  input  logic [19:0] din,
  output logic        busy,
  output logic        bcd_valid,
  output logic [27:0] bcd_out,
  output logic [7:0]  an,
  output logic [7:0]  seg
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             state;
  logic [4:0]         iter;
  logic [19:0]        bin_sr;
  logic [27:0]        bcd_sr;
  logic [47:0]        shifted;
  logic [CNT_W-1:0]   scan_cnt;
  logic [2:0]         idx;
  logic [2:0]         idx_next;
  logic               last_scan;
  logic [27:0]        bcd_next;

  // Add 3 to every BCD nibble that is 5 or more, ahead of the left shift.
  function automatic logic [27:0] dabble_adjust(input logic [27:0] b);
    logic [27:0] r;
    r = b;
    for (int i = 0; i < 7; i++) begin
      if (b[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = b[i*4 +: 4] + 4'd3;
    end
    return r;
  endfunction

  function automatic logic [7:0] seg_pattern(input logic [3:0] nib);
    logic [7:0] p;
    case (nib)
      4'd0: p = 8'hC0;
      4'd1: p = 8'hF9;
      4'd2: p = 8'hA4;
      4'd3: p = 8'hB0;
      4'd4: p = 8'h99;
      4'd5: p = 8'h92;
      4'd6: p = 8'h82;
      4'd7: p = 8'hF8;
      4'd8: p = 8'h80;
      4'd9: p = 8'h90;
      default: p = 8'hFF;
    endcase
    return p;
  endfunction

  // Segment pattern for digit position d of the latched value v.
  function automatic logic [7:0] digit_seg(input logic [27:0] v, input logic [2:0] d);
    logic [7:0] pat;
`ifdef LEADING_ZERO_BLANK_EN
    logic [2:0] msd;
`endif
    if (d == 3'd7) begin
      pat = 8'hFF;
    end else begin
      pat = seg_pattern(v[int'(d)*4 +: 4]);
    end
`ifdef LEADING_ZERO_BLANK_EN
    // msd stays 0 for a zero value so digit 0 still shows '0'.
    msd = 3'd0;
    for (int i = 1; i < 7; i++) begin
      if (v[i*4 +: 4] != 4'd0) msd = 3'(i);
    end
    if (d > msd) pat = 8'hFF;
`endif
    return pat;
  endfunction

  always_comb begin
    shifted   = {dabble_adjust(bcd_sr), bin_sr} << 1;
    last_scan = (scan_cnt == CNT_W'(SCAN_DIV - 1));
    idx_next  = last_scan ? idx + 3'd1 : idx;
    // The display sees the value bcd_out is about to take, so seg tracks
    // bcd_out without a one-cycle lag and never sees the shift register.
    bcd_next  = (state == DONE) ? bcd_sr : bcd_out;
  end

  // Control FSM: accept, 20 shift iterations, one DONE cycle that latches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      iter      <= '0;
      busy      <= 1'b0;
      bcd_valid <= 1'b0;
      bcd_out   <= '0;
    end else begin
      bcd_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (din_valid) begin
            state <= SHIFT;
            busy  <= 1'b1;
            iter  <= '0;
          end
        end
        SHIFT: begin
          iter <= iter + 5'd1;
          if (iter == 5'd19) state <= DONE;
        end
        DONE: begin
          state     <= IDLE;
          busy      <= 1'b0;
          bcd_valid <= 1'b1;
          bcd_out   <= bcd_sr;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Double-dabble datapath; contents only matter between accept and DONE.
  always_ff @(posedge clk) begin
    if (state == IDLE && din_valid) begin
      bin_sr <= din;
      bcd_sr <= '0;
    end else if (state == SHIFT) begin
      {bcd_sr, bin_sr} <= shifted;
    end
  end

  // Display scan: an and seg are registered together from the same index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt <= '0;
      idx      <= 3'd0;
      an       <= 8'hFE;
      seg      <= 8'hC0;
    end else begin
      scan_cnt <= last_scan ? '0 : scan_cnt + CNT_W'(1);
      idx      <= idx_next;
      an       <= ~(8'd1 << idx_next);
      seg      <= digit_seg(bcd_next, idx_next);
    end
  end

endmodule

// File: tb/tb_prime_seg_display.sv
// Testbench for prime_seg_display with SCAN_DIV = 4. A behavioural model
// derives every output from decimal arithmetic and elapsed cycle counts and
// is compared against the DUT each cycle; directed checks pin known values.
module tb_prime_seg_display;

  localparam int SCAN = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        din_valid = 1'b0;
  logic [19:0] din = '0;
  logic        busy;
  logic        bcd_valid;
  logic [27:0] bcd_out;
  logic [7:0]  an;
  logic [7:0]  seg;

  prime_seg_display #(.SCAN_DIV(SCAN)) dut (
    .clk(clk), .rst(rst), .din_valid(din_valid), .din(din),
    .busy(busy), .bcd_valid(bcd_valid), .bcd_out(bcd_out),
    .an(an), .seg(seg)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] seg_tab [10];

  // Model state
  int          t_m;
  bit          busy_m;
  int          age_m;
  int unsigned val_m;
  logic [27:0] bcd_m;
  bit          vld_m;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [27:0] to_bcd(input int unsigned v);
    logic [27:0] r;
    int unsigned x;
    r = '0;
    x = v;
    for (int i = 0; i < 7; i++) begin
      r[i*4 +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic [7:0] exp_seg(input logic [27:0] b, input int d);
    logic [3:0] nib;
    logic [7:0] pat;
    int msd;
    if (d == 7) return 8'hFF;
    nib = 4'((b >> (4 * d)) & 28'hF);
    pat = seg_tab[nib];
    msd = 0;
    for (int i = 0; i < 7; i++) begin
      if (((b >> (4 * i)) & 28'hF) != 0) msd = i;
    end
`ifdef LEADING_ZERO_BLANK_EN
    if (d > msd) pat = 8'hFF;
`endif
    return pat;
  endfunction

  // Model step and per-cycle compare, one time unit after each rising edge.
  always begin
    logic [7:0] ea;
    int d;
    @(posedge clk);
    #1;
    if (rst) begin
      t_m = 0; busy_m = 0; age_m = 0; bcd_m = '0; vld_m = 0;
    end else begin
      t_m++;
      vld_m = 0;
      if (busy_m) begin
        age_m++;
        if (age_m == 21) begin
          bcd_m  = to_bcd(val_m);
          vld_m  = 1;
          busy_m = 0;
        end
      end else if (din_valid) begin
        busy_m = 1;
        age_m  = 0;
        val_m  = din;
      end
    end
    d  = (t_m / SCAN) % 8;
    ea = ~(8'd1 << d);
    check("model_busy", busy, busy_m);
    check("model_bcd_valid", bcd_valid, vld_m);
    check("model_bcd_out", bcd_out, bcd_m);
    check("model_an", an, ea);
    check("model_seg", seg, exp_seg(bcd_m, d));
  end

  task automatic start(input logic [19:0] v);
    @(negedge clk);
    din = v;
    din_valid = 1'b1;
    @(negedge clk);
    din_valid = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    bit got;
    got = 0;
    n = -1;
    for (int i = 1; i <= 40 && !got; i++) begin
      @(posedge clk);
      #1;
      if (bcd_valid) begin
        got = 1;
        n = i;
      end
    end
  endtask

  task automatic wait_an(input logic [7:0] target, input string name);
    bit ok;
    ok = 0;
    for (int i = 0; i < 80 && !ok; i++) begin
      @(posedge clk);
      #1;
      if (an == target) ok = 1;
    end
    check(name, ok, 1);
  endtask

  initial begin
    int n;
    int pulses;
    int hold;
    bit done;
    logic [7:0] seq [9];
    logic [7:0] cur;
    logic [27:0] got_bcd;

    seg_tab = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
    seq = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F, 8'hFE};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_an", an, 8'hFE);
    check("rst_seg", seg, 8'hC0);
    check("rst_bcd_out", bcd_out, 28'h0);
    check("rst_busy", busy, 1'b0);
    check("rst_bcd_valid", bcd_valid, 1'b0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Value 2: latency and busy window
    start(20'd2);
    check("busy_after_accept", busy, 1'b1);
    wait_valid(n);
    check("latency_2", n, 21);
    check("bcd_2", bcd_out, 28'h0000002);
    @(posedge clk);
    #1;
    check("busy_clear_2", busy, 1'b0);
    check("valid_one_cycle_2", bcd_valid, 1'b0);

    // Full-scale value, then back-to-back accept on the first idle cycle
    start(20'hFFFFF);
    wait_valid(n);
    check("bcd_fffff", bcd_out, 28'h1048575);
    start(20'd999983);
    check("busy_back_to_back", busy, 1'b1);
    wait_valid(n);
    check("latency_b2b", n, 21);
    check("bcd_999983", bcd_out, 28'h0999983);

    // Scan pattern for 999983
    wait_an(8'hFE, "wait_an_fe");
    check("seg_digit0_3", seg, 8'hB0);
    wait_an(8'h7F, "wait_an_7f");
    check("seg_digit7_blank", seg, 8'hFF);
    wait_an(8'hFE, "wait_an_fe_seq");
    for (int s = 1; s <= 8; s++) begin
      cur  = seq[s-1];
      hold = 1;
      done = 0;
      for (int i = 0; i < 20 && !done; i++) begin
        @(posedge clk);
        #1;
        if (an == cur) hold++;
        else done = 1;
      end
      check("an_hold", hold, 4);
      check("an_step", an, seq[s]);
    end

    // 7, then 11 strobed 5 cycles later while busy
    start(20'd7);
    repeat (4) @(negedge clk);
    din = 20'd11;
    din_valid = 1'b1;
    @(negedge clk);
    din_valid = 1'b0;
    pulses = 0;
    got_bcd = '0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (bcd_valid) begin
        pulses++;
        got_bcd = bcd_out;
      end
    end
    check("drop_pulses", pulses, 1);
    check("drop_bcd_7", got_bcd, 28'h0000007);
    wait_an(8'hFD, "wait_an_fd");
`ifdef LEADING_ZERO_BLANK_EN
    check("seg_7_digit1", seg, 8'hFF);
`else
    check("seg_7_digit1", seg, 8'hC0);
`endif

    // Reset mid-conversion, then accept on the first cycle after release
    start(20'd100);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("abort_bcd_out", bcd_out, 28'h0);
    check("abort_an", an, 8'hFE);
    check("abort_seg", seg, 8'hC0);
    check("abort_busy", busy, 1'b0);
    check("abort_valid", bcd_valid, 1'b0);
    rst = 1'b0;
    din = 20'd13;
    din_valid = 1'b1;
    @(negedge clk);
    din_valid = 1'b0;
    check("busy_after_release", busy, 1'b1);
    wait_valid(n);
    check("latency_13", n, 21);
    check("bcd_13", bcd_out, 28'h0000013);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/prime_seg_display.md
PRIME_SEG_DISPLAY -- requirements
Module: prime_seg_display

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000, clk cycles per displayed digit (≥2).
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port din_valid  input  1  single-cycle strobe qualifying din.
REQ-005 SHALL have port din  input  20  unsigned binary prime value from the upstream sieve stage.
REQ-006 SHALL have port busy  output  1  high while a conversion is in progress.
REQ-007 SHALL have port bcd_valid  output  1  one-cycle pulse when bcd_out updates.
REQ-008 SHALL have port bcd_out  output  28  7 BCD digits; [3:0] = ones.
REQ-009 SHALL have port an  output  8  active-low one-hot digit enable; bit 0 = rightmost digit.
REQ-010 SHALL have port seg  output  8  active-low segments; bit 7 = dp, bits 6:0 = g..a.

Function
REQ-011 SHALL implement FSM IDLE -> SHIFT -> DONE -> IDLE, with busy = (state != IDLE).
REQ-012 In IDLE, din_valid=1 SHALL latch din and enter SHIFT on the same edge (accept edge).
REQ-013 din_valid while busy SHALL be ignored; no queuing, and the in-flight value is unaffected.
REQ-014 SHIFT SHALL run exactly 20 double-dabble iterations, one per cycle, adding 3 to every BCD nibble ≥5 before each left shift.
REQ-015 After the 20th iteration the FSM SHALL enter DONE, remain there one cycle, then return to IDLE.
REQ-016 bcd_out and bcd_valid SHALL update on the 21st edge after the accept edge; bcd_valid SHALL be high for that one cycle only.
REQ-017 A new din_valid SHALL be accepted on the first cycle after DONE, giving a back-to-back rate of one value per 22 cycles.
REQ-018 The full 20-bit range SHALL convert: 0 -> 28'h0000000 and 20'hFFFFF -> 28'h1048575.
REQ-019 A scan counter SHALL count 0..SCAN_DIV-1; at terminal count it SHALL wrap to 0 and advance the digit index 0..7, wrapping 7 -> 0.
REQ-020 an SHALL be registered as ~(1 << index); seg SHALL be registered in the same cycle as an, so an and seg never refer to different digits.
REQ-021 Digits 0..6 SHALL display bcd_out nibbles with standard patterns ('0' = 8'hC0, '1' = 8'hF9, ..., '9' = 8'h90); digit 7 SHALL always be blank (8'hFF).
REQ-022 dp SHALL always be 1 (off).
REQ-023 The display SHALL source only the latched bcd_out and SHALL never show intermediate shift-register contents.

Reset
REQ-024 rst SHALL asynchronously force: state IDLE, busy 0, bcd_valid 0, bcd_out 0, scan counter 0, index 0, an 8'hFE, seg 8'hC0.
REQ-025 rst asserted mid-conversion SHALL abort the conversion with no bcd_valid pulse; after release the block SHALL accept new data normally.
REQ-026 A din_valid in the first cycle after rst release SHALL be accepted.

Configuration
REQ-027 Macro LEADING_ZERO_BLANK_EN SHALL control leading-zero handling.
REQ-028 When LEADING_ZERO_BLANK_EN is defined, digits above the most-significant nonzero digit SHALL show 8'hFF, and value 0 SHALL show only digit 0 as '0'.
REQ-029 When LEADING_ZERO_BLANK_EN is undefined, digits 0..6 SHALL always show their values, including zeros.
REQ-030 bcd_out, timing and handshake SHALL be identical in both builds.

Verification
REQ-031 din=20'd2 pulsed at edge k -> busy=1 from k; bcd_valid=1 for exactly one cycle at k+21 with bcd_out=28'h0000002; busy=0 at k+22.
REQ-032 din=20'hFFFFF -> bcd_out=28'h1048575; din=20'd999983 -> 28'h0999983.
REQ-033 din=20'd7, then din=20'd11 strobed 5 cycles later -> bcd_out=28'h0000007; single bcd_valid pulse; second value dropped.
REQ-034 SCAN_DIV=4 -> an steps FE,FD,FB,F7,EF,DF,BF,7F,FE with each step held 4 cycles; for 999983, seg at an=FE is 8'hB0 ('3') and at an=7F is 8'hFF.
REQ-035 Value 7 with an=FD -> seg=8'hFF when LEADING_ZERO_BLANK_EN is defined, 8'hC0 when it is undefined.
REQ-036 rst pulsed 10 cycles into a conversion -> no bcd_valid pulse, bcd_out=0, an=FE, seg=C0; a subsequent din=20'd13 -> bcd_out=28'h0000013.
